// File: rtl/gray_sobel_frame_sequencer.sv
// ----------------------------------------------------------------------------
// gray_sobel_frame_sequencer
//
// Frame-level controller that sits between the SPI pixel interface and the
// gray/sobel engine. A frame is started from IDLE and the mode is latched at
// that moment. Exactly FRAME_W*FRAME_H input pixels are then admitted and
// forwarded one per cycle to the engine. Engine results are collected in a
// small output FIFO.
//
// The engine cannot be stalled once it has a pixel. For that reason a pixel
// is only issued when a FIFO slot is already reserved for its result. The
// reservation covers pixels still inside the engine (in flight) as well as
// results already waiting in the FIFO.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   nreset_i        synchronous active-low reset
//   cfg_select_i    mode (00 bypass, 01 gray, 10 sobel, 11 gray+sobel),
//                   sampled when a frame starts
//   cfg_start_i     frame start request, only honoured in IDLE
//   in_valid_i      input pixel valid
//   in_ready_o      input pixel accept (transfer = valid & ready)
//   in_pixel_i      input pixel
//   eng_select_o    latched mode to the engine
//   eng_start_o     engine enable, high while feeding or draining
//   eng_valid_o     one-cycle strobe qualifying eng_pixel_o
//   eng_pixel_o     registered pixel to the engine
//   eng_px_ready_i  engine result strobe, one per issued pixel
//   eng_pixel_i     engine result
//   out_valid_o     FIFO head valid
//   out_ready_i     consumer accept
//   out_pixel_o     FIFO head (zero while the FIFO is empty)
//   busy_o          a frame is being processed
//   frame_done_o    one-cycle pulse when a frame ends
//   err_o           [0] engine timeout, [1] unsolicited result; sticky
//                   until the next accepted start
// ----------------------------------------------------------------------------
module gray_sobel_frame_sequencer #(
  parameter int PX_W       = 24,
  parameter int FRAME_W    = 16,
  parameter int FRAME_H    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic            clk_i,
  input  logic            nreset_i,
  input  logic [1:0]      cfg_select_i,
  input  logic            cfg_start_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [PX_W-1:0] in_pixel_i,
  output logic [1:0]      eng_select_o,
  output logic            eng_start_o,
  output logic            eng_valid_o,
  output logic [PX_W-1:0] eng_pixel_o,
  input  logic            eng_px_ready_i,
  input  logic [PX_W-1:0] eng_pixel_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PX_W-1:0] out_pixel_o,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic [1:0]      err_o
);

  localparam int N      = FRAME_W * FRAME_H;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int COL_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int CRD_W  = ((CNT_W > FCNT_W) ? CNT_W : FCNT_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  inCnt_q, inCnt_d;
  logic [CNT_W-1:0]  outCnt_q, outCnt_d;
  logic [COL_W-1:0]  colCnt_q, colCnt_d;
  logic [ROW_W-1:0]  rowCnt_q, rowCnt_d;
  logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        err_q, err_d;
  logic              engValid_q, engValid_d;
  logic [PX_W-1:0]   engPixel_q, engPixel_d;

  logic [PX_W-1:0]   fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [FCNT_W-1:0] fifoCount_q, fifoCount_d;

  logic [CNT_W-1:0]  inFlight;
  logic [CRD_W-1:0]  reserved;
  logic              haveCredit;
  logic              allIssued;
  logic              lastPixel;
  logic              idleExpired;
  logic              waitingResult;
  logic              inReady;
  logic              inXfer;
  logic              startFrame;
  logic              timeoutSet;
  logic              push;
  logic              pop;
  logic              unsolicited;
  logic              outValid;

  // Slot bookkeeping. A pixel may be issued only while the results already
  // owed by the engine plus the results sitting in the FIFO leave a free
  // slot. This is what makes a push into a full FIFO impossible. The FIFO
  // count is registered, so a slot freed by a pop becomes visible one cycle
  // later and out_ready_i never reaches in_ready_o combinationally.
  always_comb begin
    inFlight      = inCnt_q - outCnt_q;
    reserved      = CRD_W'(fifoCount_q) + CRD_W'(inFlight);
    haveCredit    = reserved < CRD_W'(FIFO_DEPTH);
    allIssued     = inCnt_q >= CNT_W'(N);
    lastPixel     = (colCnt_q == COL_W'(FRAME_W - 1)) &&
                    (rowCnt_q == ROW_W'(FRAME_H - 1));
    idleExpired   = idleCnt_q == IDLE_W'(TIMEOUT);
    waitingResult = ((state_q == FEED) || (state_q == DRAIN)) &&
                    (inFlight != '0);
    inReady       = (state_q == FEED) && haveCredit && !allIssued && !idleExpired;
    inXfer        = in_valid_i && inReady;
    outValid      = fifoCount_q != '0;
    pop           = outValid && out_ready_i;
    push          = eng_px_ready_i && (inFlight != '0);
    unsolicited   = eng_px_ready_i && (inFlight == '0);
  end

  // Frame FSM next state. The watchdog can end a frame from FEED as well as
  // from DRAIN. A stalled engine stops returning results, and once every
  // slot is reserved no further pixel can be issued. Without the watchdog
  // the frame would then never reach DRAIN and would hang forever.
  always_comb begin
    state_d    = state_q;
    startFrame = 1'b0;
    timeoutSet = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          startFrame = 1'b1;
          state_d    = FEED;
        end
      end
      FEED: begin
        if (idleExpired) begin
          timeoutSet = 1'b1;
          state_d    = DONE;
        end else if (inXfer && lastPixel) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((outCnt_q == CNT_W'(N)) && !outValid) begin
          state_d = DONE;
        end else if (idleExpired) begin
          timeoutSet = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame counters, latched mode and sticky errors. A start wipes the
  // previous frame's bookkeeping. Error flags raised in the same cycle are
  // still recorded on top of that.
  always_comb begin
    inCnt_d    = inCnt_q;
    outCnt_d   = outCnt_q;
    colCnt_d   = colCnt_q;
    rowCnt_d   = rowCnt_q;
    sel_d      = sel_q;
    err_d      = err_q;
    engValid_d = inXfer;
    engPixel_d = inXfer ? in_pixel_i : engPixel_q;
    if (startFrame) begin
      inCnt_d  = '0;
      outCnt_d = '0;
      colCnt_d = '0;
      rowCnt_d = '0;
      sel_d    = cfg_select_i;
      err_d    = '0;
    end else begin
      if (inXfer) begin
        inCnt_d = inCnt_q + CNT_W'(1);
        if (colCnt_q == COL_W'(FRAME_W - 1)) begin
          colCnt_d = '0;
          rowCnt_d = (rowCnt_q == ROW_W'(FRAME_H - 1)) ? '0 : rowCnt_q + ROW_W'(1);
        end else begin
          colCnt_d = colCnt_q + COL_W'(1);
        end
      end
      if (push) begin
        outCnt_d = outCnt_q + CNT_W'(1);
      end
    end
    err_d = err_d | {unsolicited, timeoutSet};
  end

  // Engine watchdog. The counter runs only while results are owed and none
  // arrives. It saturates at TIMEOUT so it can never wrap. Any result, or
  // simply having nothing outstanding, clears it.
  always_comb begin
    idleCnt_d = '0;
    if (waitingResult && !eng_px_ready_i) begin
      idleCnt_d = idleExpired ? idleCnt_q : idleCnt_q + IDLE_W'(1);
    end
  end

  // Output FIFO pointers and occupancy. A push and a pop in the same cycle
  // leave the count unchanged. The depth is a power of two, so the pointers
  // wrap on their own.
  always_comb begin
    wrPtr_d     = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d     = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    fifoCount_d = fifoCount_q;
    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + FCNT_W'(1);
      2'b01:   fifoCount_d = fifoCount_q - FCNT_W'(1);
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  // State register. Reset overrides anything happening mid-frame.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. After reset the counters show nothing in flight,
  // so any late engine result is treated as unsolicited and dropped.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      inCnt_q     <= '0;
      outCnt_q    <= '0;
      colCnt_q    <= '0;
      rowCnt_q    <= '0;
      idleCnt_q   <= '0;
      sel_q       <= '0;
      err_q       <= '0;
      engValid_q  <= 1'b0;
      engPixel_q  <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      inCnt_q     <= inCnt_d;
      outCnt_q    <= outCnt_d;
      colCnt_q    <= colCnt_d;
      rowCnt_q    <= rowCnt_d;
      idleCnt_q   <= idleCnt_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      engValid_q  <= engValid_d;
      engPixel_q  <= engPixel_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
    end
  end

  // FIFO storage. Clearing the pointers empties the FIFO, so the array
  // itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= eng_pixel_i;
    end
  end

  assign in_ready_o   = inReady;
  assign eng_select_o = sel_q;
  assign eng_start_o  = (state_q == FEED) || (state_q == DRAIN);
  assign eng_valid_o  = engValid_q;
  assign eng_pixel_o  = engPixel_q;
  assign out_valid_o  = outValid;
  assign out_pixel_o  = outValid ? fifoMem_q[rdPtr_q] : '0;
  assign busy_o       = state_q != IDLE;
  assign frame_done_o = state_q == DONE;
  assign err_o        = err_q;

endmodule

// File: tb/tb_gray_sobel_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gray_sobel_frame_sequencer
//
// Bench for the frame sequencer on a 4x4 frame with a 4-entry FIFO. A
// behavioural engine answers each issued pixel after a programmable latency
// and can be told to stop answering. Every accepted input pushes the
// engine's expected answer onto a scoreboard. Every FIFO pop is compared
// against the head of that scoreboard.
// ----------------------------------------------------------------------------
module tb_gray_sobel_frame_sequencer;

  localparam int PX_W       = 24;
  localparam int FRAME_W    = 4;
  localparam int FRAME_H    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 100;
  localparam int N          = FRAME_W * FRAME_H;

  logic            clk_i = 1'b0;
  logic            nreset_i = 1'b0;
  logic [1:0]      cfg_select_i = 2'b00;
  logic            cfg_start_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [PX_W-1:0] in_pixel_i = '0;
  logic [1:0]      eng_select_o;
  logic            eng_start_o;
  logic            eng_valid_o;
  logic [PX_W-1:0] eng_pixel_o;
  logic            eng_px_ready_i = 1'b0;
  logic [PX_W-1:0] eng_pixel_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [PX_W-1:0] out_pixel_o;
  logic            busy_o;
  logic            frame_done_o;
  logic [1:0]      err_o;

  gray_sobel_frame_sequencer #(
    .PX_W(PX_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i),
    .cfg_select_i(cfg_select_i), .cfg_start_i(cfg_start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pixel_i(in_pixel_i),
    .eng_select_o(eng_select_o), .eng_start_o(eng_start_o),
    .eng_valid_o(eng_valid_o), .eng_pixel_o(eng_pixel_o),
    .eng_px_ready_i(eng_px_ready_i), .eng_pixel_i(eng_pixel_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pixel_o(out_pixel_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int              due;
    logic [PX_W-1:0] data;
  } engEntry_t;

  engEntry_t       engPipe[$];
  logic [PX_W-1:0] sbQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit              srcEnable = 1'b0;
  int              srcRemaining = 0;
  logic [PX_W-1:0] srcPixel = 24'h000123;
  logic [1:0]      expSel = 2'b00;
  bit              outReadyEn = 1'b0;
  int              engLatency = 2;
  int              engBudget = 1000000;
  bit              forceStrobe = 1'b0;

  int engIssued = 0;
  int srcTransfers = 0;
  int outCount = 0;
  int doneCount = 0;
  int doneCycle = 0;
  int lastResultCycle = 0;

  // The fake engine's transfer function. It depends on the mode, so a
  // wrongly latched select shows up as a data mismatch.
  function automatic logic [PX_W-1:0] engineFn(input logic [PX_W-1:0] px,
                                               input logic [1:0] sel);
    return px ^ {sel, 22'h15A5A5};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bench fabric, evaluated on the falling edge. It plays the engine, the
  // pixel source and the consumer, and drives the values the DUT will
  // sample on the next rising edge.
  always @(negedge clk_i) begin
    logic [PX_W-1:0] expPx;
    engEntry_t       entry;
    if (!nreset_i) begin
      in_valid_i     = 1'b0;
      eng_px_ready_i = 1'b0;
      out_ready_i    = 1'b0;
      engPipe.delete();
    end else begin
      if (frame_done_o) begin
        doneCount++;
        doneCycle = cyc;
      end
      if (eng_valid_o) begin
        engIssued++;
        entry.due  = cyc + engLatency;
        entry.data = engineFn(eng_pixel_o, eng_select_o);
        engPipe.push_back(entry);
      end
      eng_px_ready_i = 1'b0;
      if (forceStrobe) begin
        eng_px_ready_i = 1'b1;
        eng_pixel_i    = 24'hDEAD01;
        forceStrobe    = 1'b0;
      end else if (engPipe.size() != 0 && engPipe[0].due == cyc) begin
        entry = engPipe.pop_front();
        if (engBudget > 0) begin
          engBudget--;
          eng_px_ready_i  = 1'b1;
          eng_pixel_i     = entry.data;
          lastResultCycle = cyc;
        end
      end
      in_valid_i = srcEnable && (srcRemaining > 0);
      in_pixel_i = srcPixel;
      if (in_valid_i && in_ready_o) begin
        sbQ.push_back(engineFn(srcPixel, expSel));
        srcPixel = PX_W'($urandom);
        srcRemaining--;
        srcTransfers++;
      end
      out_ready_i = outReadyEn;
      if (out_valid_o && out_ready_i) begin
        checks++;
        outCount++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_unexpected: got %h, nothing expected", out_pixel_o);
        end else begin
          expPx = sbQ.pop_front();
          if (out_pixel_o !== expPx) begin
            errors++;
            $display("[TB] FAIL out_pixel #%0d: got %h expected %h", outCount, out_pixel_o, expPx);
          end
        end
      end
    end
  end

  // Start a frame in the given mode and stop driving the start pulse once
  // the DUT has taken it.
  task automatic applyStimulus(input logic [1:0] sel);
    @(posedge clk_i); #1;
    engIssued    = 0;
    srcTransfers = 0;
    outCount     = 0;
    doneCount    = 0;
    expSel       = sel;
    srcRemaining = N;
    srcEnable    = 1'b1;
    cfg_select_i = sel;
    cfg_start_i  = 1'b1;
    @(posedge clk_i); #1;
    cfg_start_i  = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int i;
    i = 0;
    while (doneCount == 0 && i < bound) begin
      @(posedge clk_i);
      i++;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({in_ready_o, eng_select_o, eng_start_o, eng_valid_o, eng_pixel_o, out_valid_o,
         out_pixel_o, busy_o, frame_done_o, err_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy %b sel %b outv %b err %b", busy_o, eng_select_o, out_valid_o, err_o);
    end
    nreset_i = 1'b1;
  endtask

  task automatic test_basic_frame();
    outReadyEn = 1'b1; engLatency = 2; engBudget = 1000000;
    applyStimulus(2'b10);
    checks++;
    if ({busy_o, eng_start_o, eng_select_o} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL basic_started: got %b expected 1110", {busy_o, eng_start_o, eng_select_o});
    end
    waitDone(300);
    checks++;
    if (engIssued !== N) begin errors++; $display("[TB] FAIL basic_issued: got %0d expected %0d", engIssued, N); end
    checks++;
    if (outCount !== N) begin errors++; $display("[TB] FAIL basic_outputs: got %0d expected %0d", outCount, N); end
    checks++;
    if (doneCount !== 1) begin errors++; $display("[TB] FAIL basic_done: got %0d expected 1", doneCount); end
    checks++;
    if ({busy_o, err_o, 32'(sbQ.size())} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL basic_end: busy %b err %b pending %0d expected all 0", busy_o, err_o, sbQ.size());
    end
  endtask

  task automatic test_backpressure();
    outReadyEn = 1'b0; engLatency = 3;
    applyStimulus(2'b01);
    repeat (15) @(posedge clk_i);
    #1;
    checks++;
    if (srcTransfers !== FIFO_DEPTH || engIssued !== FIFO_DEPTH) begin
      errors++;
      $display("[TB] FAIL bp_issued: got %0d/%0d expected %0d", srcTransfers, engIssued, FIFO_DEPTH);
    end
    checks++;
    if ({in_ready_o, out_valid_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_stalled: ready/outv got %b expected 01", {in_ready_o, out_valid_o});
    end
    outReadyEn = 1'b1;
    checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_before_pop: got %b expected 0", in_ready_o); end
    @(posedge clk_i); #1;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_after_pop: got %b expected 1", in_ready_o); end
    waitDone(400);
    checks++;
    if (outCount !== N || engIssued !== N) begin
      errors++;
      $display("[TB] FAIL bp_counts: outputs %0d issued %0d expected %0d", outCount, engIssued, N);
    end
    checks++;
    if (doneCount !== 1 || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_end: done %0d pending %0d expected 1/0", doneCount, sbQ.size());
    end
  endtask

  task automatic test_unsolicited();
    outReadyEn = 1'b1; engLatency = 2;
    @(posedge clk_i); #1;
    forceStrobe = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (err_o !== 2'b10) begin errors++; $display("[TB] FAIL unsol_err: got %b expected 10", err_o); end
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({out_valid_o, err_o} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL unsol_hold: outv/err got %b expected 010", {out_valid_o, err_o});
    end
    applyStimulus(2'b11);
    checks++;
    if (err_o !== 2'b00) begin errors++; $display("[TB] FAIL unsol_clear: got %b expected 00", err_o); end
    waitDone(300);
    checks++;
    if (outCount !== N || doneCount !== 1 || err_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL unsol_frame: outputs %0d done %0d err %b", outCount, doneCount, err_o);
    end
  endtask

  task automatic test_timeout();
    int gap;
    outReadyEn = 1'b1; engLatency = 2; engBudget = 10;
    applyStimulus(2'b10);
    waitDone(TIMEOUT + 300);
    gap = doneCycle - lastResultCycle;
    checks++;
    if (doneCount !== 1) begin errors++; $display("[TB] FAIL to_done: got %0d expected 1", doneCount); end
    checks++;
    if (outCount !== 10) begin errors++; $display("[TB] FAIL to_outputs: got %0d expected 10", outCount); end
    checks++;
    if (gap < TIMEOUT || gap > TIMEOUT + 4) begin
      errors++;
      $display("[TB] FAIL to_delay: got %0d cycles expected %0d..%0d", gap, TIMEOUT, TIMEOUT + 4);
    end
    checks++;
    if ({err_o, busy_o, out_valid_o} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL to_end: err/busy/outv got %b expected 0100", {err_o, busy_o, out_valid_o});
    end
    srcRemaining = 0;
    sbQ.delete();
    engBudget = 1000000;
  endtask

  task automatic test_mid_reset();
    outReadyEn = 1'b1; engLatency = 2;
    applyStimulus(2'b00);
    repeat (4) @(posedge clk_i);
    #1;
    nreset_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({in_ready_o, eng_select_o, eng_start_o, eng_valid_o, eng_pixel_o, out_valid_o,
         out_pixel_o, busy_o, frame_done_o, err_o} !== '0) begin
      errors++;
      $display("[TB] FAIL mreset_outputs: busy %b valid %b outv %b err %b", busy_o, eng_valid_o, out_valid_o, err_o);
    end
    nreset_i = 1'b1;
    sbQ.delete();
    srcRemaining = 0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({out_valid_o, err_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mreset_quiet: outv/err got %b expected 000", {out_valid_o, err_o});
    end
    applyStimulus(2'b01);
    waitDone(300);
    checks++;
    if (outCount !== N || doneCount !== 1 || sbQ.size() != 0 || err_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mreset_frame: outputs %0d done %0d pending %0d err %b", outCount, doneCount, sbQ.size(), err_o);
    end
  endtask

  task automatic test_start_ignored();
    int i;
    outReadyEn = 1'b1; engLatency = 3;
    applyStimulus(2'b10);
    i = 0;
    while (srcTransfers < N && i < 200) begin
      @(posedge clk_i);
      i++;
    end
    #1;
    checks++;
    if (srcTransfers !== N) begin errors++; $display("[TB] FAIL ign_fed: got %0d expected %0d", srcTransfers, N); end
    cfg_select_i = 2'b01;
    cfg_start_i  = 1'b1;
    @(posedge clk_i); #1;
    cfg_start_i  = 1'b0;
    checks++;
    if ({busy_o, eng_select_o} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL ign_select: busy/sel got %b expected 110", {busy_o, eng_select_o});
    end
    waitDone(300);
    checks++;
    if (outCount !== N || doneCount !== 1 || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL ign_frame: outputs %0d done %0d pending %0d", outCount, doneCount, sbQ.size());
    end
    checks++;
    if ({eng_select_o, busy_o, err_o} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL ign_end: sel/busy/err got %b expected 10000", {eng_select_o, busy_o, err_o});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_unsolicited();
    test_timeout();
    test_mid_reset();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
